// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath blocks.
package calc_pkg;

    // Controller states of the sequential divider.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Default operand width of the calculator datapath.
    localparam int CALC_WIDTH = 8;

endpackage

// File: rtl/full_sub_nbits.sv
// Ripple-borrow subtractor: s_o[width-1:0] = a_i - b_i, s_o[width] = final borrow.
module full_sub_nbits #(
    parameter int width = 8
) (
    input  logic [width-1:0] a_i,
    input  logic [width-1:0] b_i,
    output logic [width:0]   s_o
);

    logic [width:0] borrow;

    assign borrow[0] = 1'b0;

    // One full-subtractor stage per bit, borrow rippling upwards.
    for (genvar i = 0; i < width; i++) begin : g_stage
        assign s_o[i]        = a_i[i] ^ b_i[i] ^ borrow[i];
        assign borrow[i + 1] = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & borrow[i]);
    end

    assign s_o[width] = borrow[width];

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequential restoring divider: one quotient bit per RUN cycle through a
// single shared subtractor; divide-by-zero short-circuits straight to DONE.
//
// Handshake: a request is accepted on a rising edge where start_i=1 and the
// controller is IDLE (busy_o=0); start_i is ignored otherwise and nothing is
// queued. done_o pulses for one cycle when the result registers have just
// been written; they then hold until the next result is written.
module div_seq_ctrl
    import calc_pkg::*;
#(
    parameter int width = CALC_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [width-1:0] dividend_i,
    input  logic [width-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [width-1:0] quotient_o,
    output logic [width-1:0] remainder_o,
    output logic             div_by_zero_o
);

    localparam int CW = $clog2(width) + 1;

    div_state_t     state;
    div_state_t     state_next;
    logic [width-1:0] r_q;
    logic [width-1:0] q_q;
    logic [width-1:0] d_q;
    logic [CW-1:0]    cnt_q;

    logic [width:0]   trial;
    logic [width+1:0] diff;
    logic             borrow;
    logic [width-1:0] r_next;
    logic [width-1:0] q_next;
    logic             last_iter;
    logic             accept;
    logic             unused_diff;

    // Trial subtract of the shifted partial remainder against the divisor.
    assign trial = {r_q, q_q[width-1]};

    full_sub_nbits #(.width(width + 1)) u_sub (
        .a_i (trial),
        .b_i ({1'b0, d_q}),
        .s_o (diff)
    );

    assign borrow      = diff[width+1];
    // R < D keeps the committed difference inside width bits.
    assign unused_diff = diff[width];
    assign r_next      = borrow ? trial[width-1:0] : diff[width-1:0];
    assign q_next      = {q_q[width-2:0], ~borrow};
    assign last_iter   = (cnt_q == CW'(width - 1));
    assign accept      = (state == IDLE) && start_i;

    assign busy_o = (state != IDLE);
    assign done_o = (state == DONE);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (divisor_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Working registers and result registers; results only written on DONE entry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_q           <= '0;
            q_q           <= '0;
            d_q           <= '0;
            cnt_q         <= '0;
            quotient_o    <= '0;
            remainder_o   <= '0;
            div_by_zero_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        r_q   <= '0;
                        q_q   <= dividend_i;
                        d_q   <= divisor_i;
                        cnt_q <= '0;
                        if (divisor_i == '0) begin
                            quotient_o    <= '1;
                            remainder_o   <= dividend_i;
                            div_by_zero_o <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r_q   <= r_next;
                    q_q   <= q_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_iter) begin
                        quotient_o    <= q_next;
                        remainder_o   <= r_next;
                        div_by_zero_o <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Bench for div_seq_ctrl: directed cases from the test plan plus random
// operand pairs, checked against plain '/' and '%' arithmetic.
module tb_div_seq_ctrl;

  localparam int W = 8;
  localparam int RES_W = 2 * W + 1;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         dbz;

  int checks;
  int failures;

  // expected result packed as {div_by_zero, quotient, remainder}
  logic [RES_W-1:0] exp_q[$];
  logic [RES_W-1:0] last_res;

  div_seq_ctrl #(.width(W)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .dividend_i    (dividend),
    .divisor_i     (divisor),
    .busy_o        (busy),
    .done_o        (done),
    .quotient_o    (quotient),
    .remainder_o   (remainder),
    .div_by_zero_o (dbz)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // reference model: unsigned division with the divide-by-zero convention
  function automatic logic [RES_W-1:0] model(input int a, input int b);
    int q;
    int r;
    if (b == 0) begin
      q = (1 << W) - 1;
      r = a;
      return {1'b1, W'(q), W'(r)};
    end
    q = a / b;
    r = a % b;
    return {1'b0, W'(q), W'(r)};
  endfunction

  function automatic logic [RES_W-1:0] observed();
    return {dbz, quotient, remainder};
  endfunction

  // Issue one division. inject_k >= 1: pulse a second start (9/3) in that
  // cycle after acceptance. rst_k >= 1: assert reset in that cycle.
  task automatic run_op(input int a, input int b, input int inject_k, input int rst_k);
    logic [RES_W-1:0] exp_res;
    logic [RES_W-1:0] got_res;
    int k;
    int busy_cnt;
    int done_cnt;
    bit got_done;
    bit stable_ok;

    @(negedge clk);
    check_val("idle_busy", 32'(busy), 32'd0);
    check_val("idle_hold", 32'(observed() == last_res), 32'd1);
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    exp_res  = model(a, b);
    if (rst_k < 1) exp_q.push_back(exp_res);

    @(posedge clk);
    #1;
    start     = 1'b0;
    k         = 1;
    busy_cnt  = 0;
    got_done  = 1'b0;
    stable_ok = 1'b1;

    while (!got_done && k <= 20) begin
      if (k == rst_k) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_val("rst_quotient", 32'(quotient), 32'd0);
        check_val("rst_remainder", 32'(remainder), 32'd0);
        check_val("rst_dbz", 32'(dbz), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
          if (done) done_cnt++;
          @(posedge clk);
          #1;
        end
        check_val("rst_no_done", 32'(done_cnt), 32'd0);
        last_res = '0;
        return;
      end
      if (busy) busy_cnt++;
      if (done) begin
        got_done = 1'b1;
        if (exp_q.size() == 0) begin
          check_val("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_res = exp_q.pop_front();
          got_res = observed();
          check_val("quotient", 32'(got_res[2*W-1:W]), 32'(exp_res[2*W-1:W]));
          check_val("remainder", 32'(got_res[W-1:0]), 32'(exp_res[W-1:0]));
          check_val("div_by_zero", 32'(got_res[2*W]), 32'(exp_res[2*W]));
          check_val("latency", 32'(k), (b == 0) ? 32'd1 : 32'(W + 1));
          check_val("busy_cycles", 32'(busy_cnt), (b == 0) ? 32'd1 : 32'(W + 1));
          last_res = exp_res;
        end
      end else begin
        if (observed() != last_res) stable_ok = 1'b0;
      end
      if (k == inject_k) begin
        start    = 1'b1;
        dividend = W'(9);
        divisor  = W'(3);
      end else begin
        start = 1'b0;
      end
      if (!got_done) begin
        @(posedge clk);
        #1;
        k++;
      end
    end

    if (!got_done) check_val("done_timeout", 32'd0, 32'd1);
    check_val("hold_during_run", 32'(stable_ok), 32'd1);

    // first cycle after DONE: back in IDLE, results still held, no second pulse
    start = 1'b0;
    @(posedge clk);
    #1;
    check_val("post_done", 32'(done), 32'd0);
    check_val("post_busy", 32'(busy), 32'd0);
    check_val("post_hold", 32'(observed() == last_res), 32'd1);
  endtask

  initial begin
    int a;
    int b;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    last_res = '0;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("reset_busy", 32'(busy), 32'd0);
    check_val("reset_done", 32'(done), 32'd0);
    check_val("reset_quotient", 32'(quotient), 32'd0);
    check_val("reset_remainder", 32'(remainder), 32'd0);
    check_val("reset_dbz", 32'(dbz), 32'd0);

    // directed cases
    run_op(100, 7, -1, -1);
    check_val("q_100_7", 32'(quotient), 32'd14);
    check_val("r_100_7", 32'(remainder), 32'd2);
    run_op(255, 1, -1, -1);
    run_op(5, 9, -1, -1);
    run_op(255, 255, -1, -1);
    run_op(42, 0, -1, -1);
    run_op(200, 13, 4, -1);
    run_op(100, 7, -1, 5);
    run_op(50, 6, -1, -1);
    check_val("q_50_6", 32'(quotient), 32'd8);
    check_val("r_50_6", 32'(remainder), 32'd2);

    // random operand pairs, roughly one in ten with a zero divisor
    for (int n = 0; n < 1000; n++) begin
      a = int'($urandom_range(0, (1 << W) - 1));
      if ($urandom_range(0, 9) == 0) b = 0;
      else b = int'($urandom_range(1, (1 << W) - 1));
      run_op(a, b, -1, -1);
    end

    check_val("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
